// File: rtl/counter_10.sv
// rtl/counter_10.sv - presettable modulo-N counter with parallel load, dual enables and ripple carry
//
// Optional feature macro: COUNTER_10_LOAD_CLAMP_EN (loads of out-of-range values store 0)
//
// Ports:
//   clk   - rising-edge clock
//   clrn  - synchronous clear, active-high (highest priority)
//   ldn   - synchronous parallel load, active-low
//   ent   - count enable T, also gates rco
//   enp   - count enable P
//   din   - parallel load data (zero-extended or truncated to qout_width)
//   qout  - registered count value
//   rco   - ripple carry out: ent AND (qout == counter_size-1)
module counter_10 #(
    parameter int din_width    = 4,
    parameter int qout_width   = 4,
    parameter int counter_size = 10
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  ldn,
    input  logic                  ent,
    input  logic                  enp,
    input  logic [din_width-1:0]  din,
    output logic [qout_width-1:0] qout,
    output logic                  rco
);

    localparam logic [qout_width-1:0] last = qout_width'(counter_size - 1);
    localparam logic [qout_width-1:0] one  = qout_width'(1);

    logic [qout_width-1:0] din_fit;
    logic [qout_width-1:0] load_val;

    // Match din to the counter width: zero-extend a narrow bus, drop high bits of a wide one.
    generate
        if (din_width >= qout_width) begin : g_din_trunc
            assign din_fit = din[qout_width-1:0];
        end else begin : g_din_ext
            assign din_fit = {{(qout_width - din_width){1'b0}}, din};
        end
    endgenerate

`ifdef COUNTER_10_LOAD_CLAMP_EN
    // Keep the stored value inside 0..N-1 so the counter can never leave its range.
    assign load_val = (din_fit > last) ? '0 : din_fit;
`else
    assign load_val = din_fit;
`endif

    always_ff @(posedge clk) begin
        if (clrn) begin
            qout <= '0;
        end else if (!ldn) begin
            qout <= load_val;
        end else if (ent && enp) begin
            // >= rather than == so an out-of-range loaded value also returns to 0.
            qout <= (qout >= last) ? '0 : qout + one;
        end
    end

    // Combinational so a cascaded stage sees the carry in the same cycle; enp does not gate it.
    assign rco = ent && (qout == last);

endmodule

// File: tb/tb_counter_10.sv
// tb/tb_counter_10.sv - self-checking bench for counter_10 against a behavioural model
module tb_counter_10;

    logic       clk = 1'b0;
    logic       clrn, ldn, ent, enp;
    logic [3:0] din;
    logic [3:0] qout;
    logic       rco;

    logic       cclr;
    logic [3:0] cq0, cq1;
    logic       crco0, crco1;

    int checks   = 0;
    int failures = 0;
    int model_q  = 0;

    always #5 clk = ~clk;

    counter_10 dut (
        .clk (clk), .clrn(clrn), .ldn(ldn), .ent(ent), .enp(enp),
        .din (din), .qout(qout), .rco(rco)
    );

    counter_10 cas0 (
        .clk (clk), .clrn(cclr), .ldn(1'b1), .ent(1'b1), .enp(1'b1),
        .din (4'd0), .qout(cq0), .rco(crco0)
    );

    counter_10 cas1 (
        .clk (clk), .clrn(cclr), .ldn(1'b1), .ent(crco0), .enp(1'b1),
        .din (4'd0), .qout(cq1), .rco(crco1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model of one rising edge, computed from the operating rules with integers.
    task automatic model_edge();
        if (clrn) begin
            model_q = 0;
        end else if (!ldn) begin
`ifdef COUNTER_10_LOAD_CLAMP_EN
            model_q = (int'(din) >= 10) ? 0 : int'(din);
`else
            model_q = int'(din);
`endif
        end else if (ent && enp) begin
            model_q = (model_q + 1 > 9) ? 0 : model_q + 1;
        end
    endtask

    function automatic int model_rco();
        return (ent && model_q == 9) ? 1 : 0;
    endfunction

    task automatic check_now(input string tag);
        check({tag, "_q"}, int'(qout), model_q);
        check({tag, "_rco"}, int'(rco), model_rco());
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_now(tag);
    endtask

    task automatic drive(input logic c, input logic l, input logic t, input logic p, input logic [3:0] d);
        clrn = c; ldn = l; ent = t; enp = p; din = d;
        #1;
    endtask

    initial begin
        cclr = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        // Clear from unknown state
        tick("reset");
        check("reset_const_q", int'(qout), 0);

        // Free count across a wrap
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        for (int i = 1; i <= 12; i++) begin
            tick("count");
            check("count_const_q", int'(qout), i % 10);
            check("count_const_rco", int'(rco), (i % 10 == 9) ? 1 : 0);
        end

        // Load beats enables, clear beats load
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd1);
        tick("load_prio");
        check("load_prio_const", int'(qout), 1);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd7);
        tick("clr_prio");
        check("clr_prio_const", int'(qout), 0);

        // Enable gating at terminal count
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
        tick("load9");
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
        check_now("ent_low_comb");
        check("ent_low_rco_const", int'(rco), 0);
        tick("ent_low_hold");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        check("enp_low_rco_const", int'(rco), 1);
        tick("enp_low_hold");
        check("enp_low_q_const", int'(qout), 9);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        tick("gate_wrap");
        check("gate_wrap_const", int'(qout), 0);

        // Out-of-range load then count
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd12);
        tick("oor_load");
`ifdef COUNTER_10_LOAD_CLAMP_EN
        check("oor_load_const", int'(qout), 0);
`else
        check("oor_load_const", int'(qout), 12);
`endif
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        tick("oor_count");
`ifdef COUNTER_10_LOAD_CLAMP_EN
        check("oor_count_const", int'(qout), 1);
`else
        check("oor_count_const", int'(qout), 0);
`endif

        // Mid-count clear
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
        tick("mid_pre");
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 5; i++) tick("mid_run");
        check("mid_at5", int'(qout), 5);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
        tick("mid_clr");
        check("mid_clr_const", int'(qout), 0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        tick("mid_resume");
        check("mid_resume_const", int'(qout), 1);

        // Randomised traffic against the model
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) != 0),
                  1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)));
            check_now("rand_comb");
            tick("rand");
        end

        // Two-stage cascade counting 00..99 then 00
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cclr = 1'b1;
        @(posedge clk);
        #1;
        check("cas_clear", int'(cq1) * 10 + int'(cq0), 0);
        cclr = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            check("cascade", int'(cq1) * 10 + int'(cq0), k % 100);
            check("cascade_rco", int'(crco1), (k % 100 == 99) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
